// File: rtl/nibble_packer_pkg.sv
// Shared constants and types for the nibble packer and the 32-lane adder tree.
// Both blocks agree on lane count, lane width, vector width and sum width here.
package nibble_packer_pkg;

    localparam int NUM_LANES = 32;
    localparam int LANE_W    = 4;
    localparam int VEC_W     = NUM_LANES * LANE_W;
    localparam int SUM_W     = 13;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_packer.sv
// Packs a serial stream of LANE_W-bit samples into one NUM_LANES-lane vector.
// The k-th accepted sample of a frame lands in lane k. A frame closes on
// in_last or on the final lane. The finished vector is then held behind a
// valid/ready handshake. Lanes that are not written read as zero, because the
// vector is cleared at reset and again at every handoff.
// Optional macro NIBBLE_PACKER_CNT_EN adds out_cnt: the number of samples
// written into the held vector.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int NUM_LANES = nibble_packer_pkg::NUM_LANES,
    parameter int LANE_W    = nibble_packer_pkg::LANE_W,
    parameter int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [LANE_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [NUM_LANES*LANE_W-1:0]   out_vec,
`ifdef NIBBLE_PACKER_CNT_EN
    output logic [IDX_W:0]                out_cnt,
`endif
    input  logic                          out_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             close_frame;
    logic             handoff;

    assign in_ready    = (state_q == FILL);
    assign out_valid   = (state_q == HOLD);
    assign accept      = in_valid && in_ready;
    assign close_frame = accept && (in_last || (wr_idx == LAST_IDX));
    assign handoff     = out_valid && out_ready;

    // State register for the fill/hold handshake FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: close the frame into HOLD, return to FILL once the consumer takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close_frame) state_d = HOLD;
            HOLD:    if (handoff)     state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Lane register and write index; clearing at handoff provides the zero padding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            out_vec <= '0;
        end else if (handoff) begin
            out_vec <= '0;
        end else if (accept) begin
            out_vec[int'(wr_idx)*LANE_W +: LANE_W] <= in_data;
            wr_idx <= close_frame ? '0 : wr_idx + 1'b1;
        end
    end

`ifdef NIBBLE_PACKER_CNT_EN
    // Sample count captured on the same edge that enters HOLD, cleared at handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (handoff) begin
            out_cnt <= '0;
        end else if (close_frame) begin
            out_cnt <= {1'b0, wr_idx} + (IDX_W+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Directed testbench for nibble_packer. Each scenario task drives its own
// stimulus and compares against hand-computed vectors.
// Build with +define+NIBBLE_PACKER_CNT_EN to also check out_cnt.
module tb_nibble_packer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_vec;
    logic         out_ready;
`ifdef NIBBLE_PACKER_CNT_EN
    logic [5:0]   out_cnt;
`endif

    int tests_run;
    int tests_failed;

    nibble_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_vec   (out_vec),
`ifdef NIBBLE_PACKER_CNT_EN
        .out_cnt   (out_cnt),
`endif
        .out_ready (out_ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sum of the 32 lanes, as the downstream adder tree would form it
    function automatic int lane_sum(input logic [127:0] v);
        int s;
        s = 0;
        for (int k = 0; k < 32; k++) s += int'(v[k*4 +: 4]);
        return s;
    endfunction

    // Present one sample and hold it until accepted; timing: called and returns #1 after a posedge
    task automatic send_nibble(input logic [3:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid);
        end
        tests_run++;
        if (out_vec !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_vec: got %h, required 0", out_vec);
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_cnt: got %0d, required 0", out_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 31; i++) send_nibble(4'hF, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_early_valid: got %0b after 31 samples, required 0", out_valid);
        end
        send_nibble(4'hF, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_valid: got %0b, required 1", out_valid);
        end
        tests_run++;
        if (out_vec !== {128{1'b1}}) begin
            tests_failed++;
            $display("[TB] FAIL full_vec: got %h, required all F", out_vec);
        end
        tests_run++;
        if (lane_sum(out_vec) != 480) begin
            tests_failed++;
            $display("[TB] FAIL full_sum: got %0d, required 480", lane_sum(out_vec));
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd32) begin
            tests_failed++;
            $display("[TB] FAIL full_cnt: got %0d, required 32", out_cnt);
        end
`endif
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL full_handoff: valid=%0b ready=%0b vec=%h, required 0 1 0",
                     out_valid, in_ready, out_vec);
        end
    endtask

    task automatic test_short_frame();
        out_ready = 1'b0;
        send_nibble(4'h1, 1'b0);
        send_nibble(4'h2, 1'b0);
        send_nibble(4'h3, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== 128'h321) begin
            tests_failed++;
            $display("[TB] FAIL short_vec: valid=%0b vec=%h, required 1 and 321", out_valid, out_vec);
        end
        tests_run++;
        if (lane_sum(out_vec) != 6) begin
            tests_failed++;
            $display("[TB] FAIL short_sum: got %0d, required 6", lane_sum(out_vec));
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd3) begin
            tests_failed++;
            $display("[TB] FAIL short_cnt: got %0d, required 3", out_cnt);
        end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_nibble(4'hA, 1'b0);
        send_nibble(4'hA, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 128'hAA) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold[%0d]: ready=%0b valid=%0b vec=%h, required 0 1 aa",
                         c, in_ready, out_valid, out_vec);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: ready=%0b valid=%0b vec=%h, required 1 0 0",
                     in_ready, out_valid, out_vec);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_vec !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL bp_single_handoff: valid=%0b vec=%h, required 0 0", out_valid, out_vec);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) send_nibble(4'h1, i == 31);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== {32{4'h1}}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_a: valid=%0b vec=%h, required 1 and all 1", out_valid, out_vec);
        end
        for (int i = 0; i < 4; i++) send_nibble(4'h2, i == 3);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== 128'h2222) begin
            tests_failed++;
            $display("[TB] FAIL b2b_frame_b: valid=%0b vec=%h, required 1 and 2222", out_valid, out_vec);
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd4) begin
            tests_failed++;
            $display("[TB] FAIL b2b_cnt: got %0d, required 4", out_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_nibble(4'h9, 1'b0);
        rst = 1'b1;
        #2;
        tests_run++;
        if (out_valid !== 1'b0 || out_vec !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL midfill_reset: valid=%0b vec=%h, required 0 0", out_valid, out_vec);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_nibble(4'h7, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== 128'h7) begin
            tests_failed++;
            $display("[TB] FAIL midfill_next: valid=%0b vec=%h, required 1 and 7", out_valid, out_vec);
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd1) begin
            tests_failed++;
            $display("[TB] FAIL midfill_cnt: got %0d, required 1", out_cnt);
        end
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        logic [3:0] d;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            d = 4'(i);
            send_nibble(d, 1'b0);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== 128'hFEDCBA9876543210FEDCBA9876543210) begin
            tests_failed++;
            $display("[TB] FAIL ovf_vec: valid=%0b vec=%h, required 1 and fedc..3210 twice", out_valid, out_vec);
        end
`ifdef NIBBLE_PACKER_CNT_EN
        tests_run++;
        if (out_cnt !== 6'd32) begin
            tests_failed++;
            $display("[TB] FAIL ovf_cnt: got %0d, required 32", out_cnt);
        end
`endif
        in_valid = 1'b1;
        in_data  = 4'hC;
        in_last  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_vec !== 128'hFEDCBA9876543210FEDCBA9876543210) begin
            tests_failed++;
            $display("[TB] FAIL ovf_wait: ready=%0b vec=%h, required 0 and held vector", in_ready, out_vec);
        end
        out_ready = 1'b1;
        send_nibble(4'hC, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_vec !== 128'hC) begin
            tests_failed++;
            $display("[TB] FAIL ovf_next: valid=%0b vec=%h, required 1 and c", out_valid, out_vec);
        end
        @(posedge clk); #1;
    endtask

    // Scenario sequence and summary
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_fill();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Upstream feeder for the 32-lane nibble adder tree.
- Collects a serial stream of 4-bit samples into one 128-bit lane vector. Lane k occupies bits [4k+3:4k], and the k-th accepted nibble of a frame lands in lane k.
- Presents the finished vector with a valid/ready handshake. The downstream stage drives the vector straight into the adder tree's 128-bit input.
- Short frames, ended early by a last flag, are zero-padded, so unused lanes add nothing to the sum.

Parameters:
- NUM_LANES, 32, lanes per output vector; must be a power of two, at least 2.
- LANE_W, 4, bits per lane / per input sample.
- IDX_W, $clog2(NUM_LANES), width of the write index (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_data  in  LANE_W  input sample.
- in_last  in  1  sample closes the frame; qualified by in_valid.
- in_ready  out  1  packer accepts a sample this cycle.
- out_valid  out  1  out_vec holds a complete vector.
- out_vec  out  NUM_LANES*LANE_W  packed lanes; lane k = bits [LANE_W*k+LANE_W-1 : LANE_W*k].
- out_ready  in  1  consumer takes the vector this cycle.

Behaviour:
- Reset (async assert, sampled deassert on clk):
  - state = FILL, wr_idx = 0, out_vec = 0, out_valid = 0.
  - in_ready = 1 from the first clock edge after deassert.
- States:
  - FILL: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Accept = in_valid && in_ready. On accept in FILL:
  - write in_data into lane wr_idx; all other lanes keep their value.
  - if in_last or wr_idx == NUM_LANES-1: go to HOLD, wr_idx = 0.
  - otherwise wr_idx = wr_idx + 1.
- Latency: out_valid rises the cycle after the closing nibble is accepted. A full vector takes NUM_LANES accept cycles plus at least one HOLD cycle, so peak throughput is one vector per NUM_LANES+1 cycles.
- HOLD:
  - out_vec and out_valid stay stable while out_ready = 0; backpressure is unbounded.
  - in_valid is ignored; the source must hold its sample because in_ready = 0.
  - On out_valid && out_ready: out_vec cleared to 0, state returns to FILL. in_ready is high from the next cycle.
- Zero padding: lanes not written in a frame read 0. This holds because out_vec is cleared at handoff and at reset.
- in_last on the NUM_LANES-th nibble produces exactly one vector, not an extra empty vector.
- in_last is ignored when in_valid = 0. A frame cannot be empty: in_last always travels with a nibble.
- out_vec bits are never X after reset; X on in_data while in_valid = 0 has no effect.
- Reset mid-fill or mid-hold discards the partial or pending vector. The next accepted nibble goes to lane 0.
- No arithmetic is performed here. The downstream sum range is 0..NUM_LANES*(2^LANE_W-1), i.e. 480 for the defaults, which fits 13 bits.

Optional Feature:
- Macro: NIBBLE_PACKER_CNT_EN.
- Defined:
  - extra output port out_cnt, width IDX_W+1, holding the number of nibbles written into the held vector (1..NUM_LANES).
  - out_cnt is registered together with the HOLD transition, stable during HOLD, and reset/cleared to 0.
  - Lets the consumer form averages.
- Undefined: port and counter register absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - lane constants: NUM_LANES = 32, LANE_W = 4, VEC_W = 128, SUM_W = 13.
  - state enum {FILL, HOLD}.
  - The adder tree uses the same constants.
- No sub-module required; a single module holds the FSM, index counter and lane register.
- A one-register lane-write helper is not worth splitting out.

Test Plan:
- Full frame: 32 nibbles of 0xF, in_last on the 32nd, out_ready = 1 → out_valid rises one cycle after the last accept; out_vec = all-F (128 bits); downstream sum = 480; out_cnt = 32 if enabled.
- Short frame: nibbles 1, 2, 3, in_last on 3 → out_vec = 0x…000321, upper 29 lanes zero; sum = 6; out_cnt = 3.
- Backpressure: complete vector with out_ready = 0 for 5 cycles and in_valid held at 1 → out_vec unchanged, in_ready = 0 throughout. On out_ready = 1 there is exactly one handoff and in_ready = 1 the next cycle.
- Back-to-back frames: frame A = 0x1 × 32, frame B = 0x2 × 4 + last → second vector has lanes 0..3 = 2 and all others 0; no stale 0x1 lanes.
- Reset mid-fill: 10 nibbles accepted, then rst pulse → out_valid = 0, out_vec = 0; the next nibble 0x7 with last lands in lane 0; out_vec = 0x7.
- No-last overflow: 33 nibbles with no in_last → vector closes at nibble 32; nibble 33 waits (in_ready = 0) and becomes lane 0 of the next vector.
